// File: rtl/hazard_forward_unit_if.sv
// ID-stage request and forward/stall response bundle for hazard_forward_unit.
// The pipeline front end drives the ID fields; the hazard unit returns stall and selects.
interface hazard_forward_unit_if #(
    parameter int AW             = 5,
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 2
);
    localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

    logic                       i_id_valid;
    logic [NUM_SRC*AW-1:0]      i_id_rs_addr;
    logic [NUM_SRC-1:0]         i_id_rs_used;
    logic [AW-1:0]              i_id_rd_addr;
    logic                       i_id_rd_wren;
    logic                       i_id_is_load;
    logic                       i_flush;
    logic                       i_stall_ext;
    logic                       o_stall;
    logic [NUM_SRC*SEL_W-1:0]   o_fwd_sel;

    modport master (
        output i_id_valid, i_id_rs_addr, i_id_rs_used, i_id_rd_addr,
               i_id_rd_wren, i_id_is_load, i_flush, i_stall_ext,
        input  o_stall, o_fwd_sel
    );

    modport slave (
        input  i_id_valid, i_id_rs_addr, i_id_rs_used, i_id_rd_addr,
               i_id_rd_wren, i_id_is_load, i_flush, i_stall_ext,
        output o_stall, o_fwd_sel
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use stall unit with an internal in-flight destination tracker.
// Entry 0 mirrors EX; selects are computed in ID and registered so they line up with EX.
module hfu_src_sel #(
    parameter int AW         = 5,
    parameter int NUM_FWD    = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 2
) (
    input  logic [AW-1:0]               src,
    input  logic                        used,
    input  logic [NUM_FWD-1:0]          wr_hit,
    input  logic [NUM_FWD-1:0][AW-1:0]  rd_vec,
    input  logic [NUM_FWD-1:0]          ld_flag,
    output logic [SEL_W-1:0]            sel,
    output logic                        load_hit
);
    // Scan oldest to youngest so the youngest matching writer overrides.
    always_comb begin
        sel      = '0;
        load_hit = 1'b0;
        if (used) begin
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
                if (wr_hit[j] && rd_vec[j] == src) begin
                    sel      = SEL_W'(j + 1);
                    load_hit = ld_flag[j] && (j + 1 < LOAD_STAGE);
                end
            end
        end
    end
endmodule

module hazard_forward_unit #(
    parameter int AW             = 5,
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_STAGE     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    hazard_forward_unit_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          wren;
        logic          is_load;
    } entry_t;

    entry_t [NUM_FWD_STAGES-1:0]          trk;
    entry_t                               id_ent;
    logic   [NUM_FWD_STAGES-1:0]          wr_hit;
    logic   [NUM_FWD_STAGES-1:0]          ld_flag;
    logic   [NUM_FWD_STAGES-1:0][AW-1:0]  rd_vec;
    logic   [NUM_SRC-1:0][SEL_W-1:0]      sel_nxt;
    logic   [NUM_SRC-1:0][SEL_W-1:0]      sel_q;
    logic   [NUM_SRC-1:0]                 ld_hit;

    // x0 is never a writer, so a read of x0 can never pick up a forward.
    for (genvar j = 0; j < NUM_FWD_STAGES; j++) begin : g_trk
        assign wr_hit[j]  = trk[j].valid & trk[j].wren & (trk[j].rd != '0);
        assign rd_vec[j]  = trk[j].rd;
        assign ld_flag[j] = trk[j].is_load;
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hfu_src_sel #(
            .AW(AW), .NUM_FWD(NUM_FWD_STAGES), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
        ) u_src (
            .src      (bus.i_id_rs_addr[k*AW +: AW]),
            .used     (bus.i_id_rs_used[k]),
            .wr_hit   (wr_hit),
            .rd_vec   (rd_vec),
            .ld_flag  (ld_flag),
            .sel      (sel_nxt[k]),
            .load_hit (ld_hit[k])
        );
    end

    assign id_ent = '{valid: bus.i_id_valid, rd: bus.i_id_rd_addr,
                      wren: bus.i_id_rd_wren, is_load: bus.i_id_is_load};

    assign bus.o_stall   = bus.i_id_valid & ~bus.i_flush & (|ld_hit);
    assign bus.o_fwd_sel = sel_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            trk   <= '0;
            sel_q <= '0;
        end else if (!bus.i_stall_ext) begin
            if (bus.i_flush) begin
                // ID and EX are killed; MEM and beyond keep draining.
                for (int j = 2; j < NUM_FWD_STAGES; j++) trk[j] <= trk[j-1];
                trk[1] <= '0;
                trk[0] <= '0;
                sel_q  <= '0;
            end else begin
                for (int j = 1; j < NUM_FWD_STAGES; j++) trk[j] <= trk[j-1];
                trk[0] <= bus.o_stall ? '0 : id_ent;
                sel_q  <= (bus.o_stall || !bus.i_id_valid) ? '0 : sel_nxt;
            end
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed plus randomized bench for hazard_forward_unit against a queue-based model
// of the in-flight instruction window (youngest first).
module tb_hazard_forward_unit;
    localparam int AW = 5, NS = 2, NF = 2, LS = 2;
    localparam int SW = $clog2(NF + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.AW(AW), .NUM_SRC(NS), .NUM_FWD_STAGES(NF)) bus ();

    hazard_forward_unit #(.AW(AW), .NUM_SRC(NS), .NUM_FWD_STAGES(NF), .LOAD_STAGE(LS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int   n_chk = 0;
    int   n_err = 0;
    logic obs_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        bit v;
        int rd;
        bit w;
        bit ld;
    } ent_t;

    ent_t pipe[$];
    int   exp_sel[NS];

    function automatic void find(input int src, input bit used, output int sel, output bit ldh);
        sel = 0;
        ldh = 0;
        if (!used) return;
        for (int j = 0; j < pipe.size(); j++) begin
            if (pipe[j].v && pipe[j].w && pipe[j].rd != 0 && pipe[j].rd == src) begin
                sel = j + 1;
                ldh = pipe[j].ld && (j + 1 < LS);
                return;
            end
        end
    endfunction

    task automatic step(input bit rst, input bit vld, input int rs0, input int rs1,
                        input bit [1:0] used, input int rd, input bit wren, input bit ld,
                        input bit fl, input bit sx);
        int          s;
        bit          h;
        bit          exp_stall;
        int          nsel[NS];
        logic [31:0] ev;
        ent_t        bub;
        ent_t        nw;
        bub = '{0, 0, 0, 0};
        nw  = '{vld, rd, wren, ld};
        @(negedge clk);
        rst_n               = !rst;
        bus.i_id_valid      = vld;
        bus.i_id_rs_addr    = {AW'(rs1), AW'(rs0)};
        bus.i_id_rs_used    = used;
        bus.i_id_rd_addr    = AW'(rd);
        bus.i_id_rd_wren    = wren;
        bus.i_id_is_load    = ld;
        bus.i_flush         = fl;
        bus.i_stall_ext     = sx;
        exp_stall = 0;
        for (int k = 0; k < NS; k++) begin
            find((k == 0) ? rs0 : rs1, used[k], s, h);
            nsel[k] = vld ? s : 0;
            if (h) exp_stall = 1;
        end
        exp_stall = exp_stall && vld && !fl;
        #1;
        obs_stall = bus.o_stall;
        chk("stall", {31'd0, bus.o_stall}, {31'd0, exp_stall});
        @(posedge clk);
        if (rst) begin
            pipe.delete();
            for (int j = 0; j < NF; j++) pipe.push_back(bub);
            foreach (exp_sel[k]) exp_sel[k] = 0;
        end else if (sx) begin
        end else if (fl) begin
            pipe[0] = bub;
            pipe.push_front(bub);
            void'(pipe.pop_back());
            foreach (exp_sel[k]) exp_sel[k] = 0;
        end else begin
            pipe.push_front(exp_stall ? bub : nw);
            void'(pipe.pop_back());
            foreach (exp_sel[k]) exp_sel[k] = exp_stall ? 0 : nsel[k];
        end
        #1;
        ev = '0;
        for (int k = 0; k < NS; k++) ev[k*SW +: SW] = SW'(exp_sel[k]);
        chk("fwd_sel", 32'(bus.o_fwd_sel), ev);
    endtask

    task automatic ins(input int rs0, input int rs1, input bit [1:0] used,
                       input int rd, input bit wren, input bit ld);
        step(0, 1, rs0, rs1, used, rd, wren, ld, 0, 0);
    endtask

    function automatic logic [31:0] sel_of(input int k);
        logic [NS*SW-1:0] v;
        v = bus.o_fwd_sel;
        return 32'(v[k*SW +: SW]);
    endfunction

    initial begin
        bus.i_id_valid   = 0;
        bus.i_id_rs_addr = '0;
        bus.i_id_rs_used = '0;
        bus.i_id_rd_addr = '0;
        bus.i_id_rd_wren = 0;
        bus.i_id_is_load = 0;
        bus.i_flush      = 0;
        bus.i_stall_ext  = 0;
        for (int j = 0; j < NF; j++) pipe.push_back('{0, 0, 0, 0});
        foreach (exp_sel[k]) exp_sel[k] = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_sel", 32'(bus.o_fwd_sel), 0);
        chk("rst_stall", {31'd0, bus.o_stall}, 0);

        // ALU chain: distance 1 forwards from MEM
        ins(0, 0, 2'b00, 5, 1, 0);
        ins(5, 0, 2'b01, 0, 0, 0);
        chk("chain_s0", sel_of(0), 1);
        chk("chain_s1", sel_of(1), 0);

        // distance 2 -> WB, distance 3 -> regfile
        ins(0, 0, 2'b00, 7, 1, 0);
        ins(0, 0, 2'b00, 1, 1, 0);
        ins(0, 7, 2'b10, 0, 0, 0);
        chk("dist2", sel_of(1), 2);
        ins(0, 0, 2'b00, 7, 1, 0);
        ins(0, 0, 2'b00, 1, 1, 0);
        ins(0, 0, 2'b00, 2, 1, 0);
        ins(0, 7, 2'b10, 0, 0, 0);
        chk("dist3", sel_of(1), 0);

        // youngest writer wins
        ins(0, 0, 2'b00, 3, 1, 0);
        ins(0, 0, 2'b00, 3, 1, 0);
        ins(3, 0, 2'b01, 0, 0, 0);
        chk("double", sel_of(0), 1);

        // load-use: one stall cycle, then forward from WB
        ins(0, 0, 2'b00, 9, 1, 1);
        ins(9, 0, 2'b01, 0, 0, 0);
        chk("lu_stall", {31'd0, obs_stall}, 1);
        chk("lu_bubble", sel_of(0), 0);
        ins(9, 0, 2'b01, 0, 0, 0);
        chk("lu_clear", {31'd0, obs_stall}, 0);
        chk("lu_fwd", sel_of(0), 2);

        // x0 and unused sources
        ins(0, 0, 2'b00, 0, 1, 0);
        ins(0, 0, 2'b01, 0, 0, 0);
        chk("x0", sel_of(0), 0);
        ins(0, 0, 2'b00, 4, 1, 1);
        ins(4, 4, 2'b00, 0, 0, 0);
        chk("unused", {31'd0, obs_stall}, 0);

        // flush kills the load in EX
        ins(0, 0, 2'b00, 6, 1, 1);
        step(0, 1, 6, 0, 2'b01, 0, 0, 0, 1, 0);
        chk("flush_stall", {31'd0, obs_stall}, 0);
        ins(6, 0, 2'b01, 0, 0, 0);
        chk("flush_fwd", sel_of(0), 0);

        // external freeze holds selects and tracker
        ins(0, 0, 2'b00, 5, 1, 0);
        ins(5, 0, 2'b01, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 2'b00, 8, 1, 0, 0, 1);
            chk("freeze", sel_of(0), 1);
        end
        ins(0, 5, 2'b10, 0, 0, 0);
        chk("after_freeze", sel_of(1), 2);

        // reset mid-stream clears in-flight state
        ins(0, 0, 2'b00, 5, 1, 0);
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("mid_rst", 32'(bus.o_fwd_sel), 0);
        ins(5, 0, 2'b01, 0, 0, 0);
        chk("post_rst", sel_of(0), 0);

        // randomized traffic over a small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
